// File: rtl/serial_sum_deserializer.sv
// serial_sum_deserializer
// Receive end of the bit-serial adder: gathers an LSB-first sum stream plus
// the final carry into a WIDTH-bit word and offers it over valid/ready.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        one-cycle pulse, begins (or restarts) a frame
//   s_in         serial sum bit, LSB first
//   s_valid      qualifies s_in
//   c_in         adder carry, sampled with the WIDTH-th bit only
//   result       assembled sum word
//   carry_out    captured final carry
//   out_valid    result/carry_out valid
//   out_ready    downstream accept
//   busy         state is not IDLE
//   frame_abort  one-cycle pulse when an in-progress frame is restarted
//   parity_out   (SER_SUM_PARITY_EN only) even parity over result and carry_out
//
// Optional feature macro: SER_SUM_PARITY_EN
module serial_sum_deserializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             c_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             out_valid,
    output logic             busy,
`ifdef SER_SUM_PARITY_EN
    output logic             parity_out,
`endif
    output logic             frame_abort
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_n;
    logic             restart;
    logic             last_bit;
    logic             capture;
    logic             out_valid_n;
    logic             busy_n;
    logic             abort_n;

    // A start is honoured in IDLE, SHIFT (abort) and HOLD only with a handshake.
    assign restart  = start && ((state == IDLE) || (state == SHIFT) ||
                                ((state == HOLD) && out_ready));
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) state_n = SHIFT;
            end
            SHIFT: begin
                if (!start && s_valid && last_bit) state_n = HOLD;
            end
            HOLD: begin
                if (out_ready) state_n = start ? SHIFT : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        shreg_n     = shreg;
        cnt_n       = cnt;
        capture     = 1'b0;
        out_valid_n = (state_n == HOLD);
        busy_n      = (state_n != IDLE);
        abort_n     = start && (state == SHIFT);
        if (restart) begin
            // A bit arriving with start is bit 0 of the new frame.
            shreg_n = s_valid ? {s_in, {(WIDTH-1){1'b0}}} : '0;
            cnt_n   = s_valid ? CNT_W'(1) : '0;
        end else if ((state == SHIFT) && s_valid) begin
            shreg_n = {s_in, shreg[WIDTH-1:1]};
            cnt_n   = cnt + CNT_W'(1);
            capture = last_bit;
        end
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            shreg       <= '0;
            result      <= '0;
            carry_out   <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_abort <= 1'b0;
`ifdef SER_SUM_PARITY_EN
            parity_out  <= 1'b0;
`endif
        end else begin
            cnt         <= cnt_n;
            shreg       <= shreg_n;
            out_valid   <= out_valid_n;
            busy        <= busy_n;
            frame_abort <= abort_n;
            if (capture) begin
                result     <= shreg_n;
                carry_out  <= c_in;
`ifdef SER_SUM_PARITY_EN
                parity_out <= ^{c_in, shreg_n};
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// Self-checking bench for serial_sum_deserializer (WIDTH=8): directed
// scenarios plus randomized frames compared against a frame-level model.
module tb_serial_sum_deserializer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic         s_in;
    logic         s_valid;
    logic         c_in;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         out_valid;
    logic         busy;
    logic         frame_abort;
`ifdef SER_SUM_PARITY_EN
    logic         parity_out;
`endif

    serial_sum_deserializer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .s_in        (s_in),
        .s_valid     (s_valid),
        .c_in        (c_in),
        .out_ready   (out_ready),
        .result      (result),
        .carry_out   (carry_out),
        .out_valid   (out_valid),
        .busy        (busy),
`ifdef SER_SUM_PARITY_EN
        .parity_out  (parity_out),
`endif
        .frame_abort (frame_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int abort_cnt = 0;
    int busy_low  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        else
            pass_cnt++;
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 collecting bits, 2 word on offer
    int           phase;
    int           nbits;
    logic [W-1:0] acc;
    logic [W-1:0] m_res;
    logic         m_carry;
    logic         m_par;
    logic         m_abort;

    task automatic take_bit();
        if (s_valid) begin
            acc = acc | (W'(s_in) << nbits);
            nbits++;
            if (nbits == W) begin
                m_res   = acc;
                m_carry = c_in;
                m_par   = ^{acc, c_in};
                phase   = 2;
            end
        end
    endtask

    task automatic begin_frame();
        phase = 1;
        nbits = 0;
        acc   = '0;
        take_bit();
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase = 0; nbits = 0; acc = '0; m_res = '0;
            m_carry = 1'b0; m_par = 1'b0; m_abort = 1'b0;
        end else begin
            m_abort = 1'b0;
            if (phase == 0) begin
                if (start) begin_frame();
            end else if (phase == 1) begin
                if (start) begin
                    m_abort = 1'b1;
                    begin_frame();
                end else begin
                    take_bit();
                end
            end else begin
                if (out_ready) begin
                    if (start) begin_frame();
                    else phase = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(phase == 2));
        chk("busy", 32'(busy), 32'(phase != 0));
        chk("frame_abort", 32'(frame_abort), 32'(m_abort));
        chk("result", 32'(result), 32'(m_res));
        chk("carry_out", 32'(carry_out), 32'(m_carry));
`ifdef SER_SUM_PARITY_EN
        chk("parity_out", 32'(parity_out), 32'(m_par));
`endif
        if (frame_abort === 1'b1) abort_cnt++;
        if (reset && busy !== 1'b1) busy_low++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // Sends a whole frame; earlier c_in values are 1 to show they are ignored.
    task automatic send_frame(input logic [W-1:0] w, input logic cy, input int gmax,
                              input logic rdy_first);
        start = 1'b1; out_ready = rdy_first;
        s_valid = 1'b1; s_in = w[0]; c_in = 1'b1;
        step();
        start = 1'b0; out_ready = 1'b0;
        for (int i = 1; i < int'(W); i++) begin
            int gaps;
            gaps = (gmax > 0) ? int'($urandom_range(1, gmax)) : 0;
            repeat (gaps) begin
                s_valid = 1'b0; s_in = 1'($urandom); c_in = 1'($urandom);
                step();
            end
            s_valid = 1'b1; s_in = w[i];
            c_in = (i == int'(W) - 1) ? cy : 1'b1;
            step();
        end
        s_valid = 1'b0; c_in = 1'b0; s_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ab0;
        int bl0;
        logic [W-1:0] w;
        logic cy;
        logic btb;
        reset = 1'b0; start = 1'b0; s_in = 1'b0; s_valid = 1'b0;
        c_in = 1'b0; out_ready = 1'b0;
        step();
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        step();
        reset = 1'b1;

        // 1: nominal frame
        send_frame(8'h96, 1'b0, 0, 1'b0);
        chk("t1_result", 32'(result), 32'h96);
        chk("t1_carry", 32'(carry_out), 32'h0);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        handshake();
        chk("t1_valid_drop", 32'(out_valid), 32'h0);

        // 2: carry capture
        send_frame(8'h00, 1'b1, 0, 1'b0);
        chk("t2_result", 32'(result), 32'h00);
        chk("t2_carry", 32'(carry_out), 32'h1);
`ifdef SER_SUM_PARITY_EN
        chk("t2_parity", 32'(parity_out), 32'h1);
`endif
        handshake();

        // 3: gaps and backpressure
        send_frame(8'h96, 1'b0, 3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_result", 32'(result), 32'h96);
            chk("t3_hold_valid", 32'(out_valid), 32'h1);
            step();
        end
        handshake();
        chk("t3_valid_drop", 32'(out_valid), 32'h0);

        // 4: abort after three bits
        ab0 = abort_cnt;
        start = 1'b1; s_valid = 1'b1; s_in = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        s_valid = 1'b0;
        send_frame(8'h0F, 1'b0, 0, 1'b0);
        chk("t4_abort_pulses", 32'(abort_cnt - ab0), 32'h1);
        chk("t4_result", 32'(result), 32'h0F);

        // 5: back-to-back from HOLD
        bl0 = busy_low;
        send_frame(8'hA5, 1'b1, 0, 1'b1);
        chk("t5_no_idle", 32'(busy_low - bl0), 32'h0);
        chk("t5_result", 32'(result), 32'hA5);
        chk("t5_carry", 32'(carry_out), 32'h1);
        handshake();

        // 6: async reset mid-frame
        start = 1'b1; s_valid = 1'b1; s_in = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        s_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'h0);
        chk("t6_result", 32'(result), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_carry", 32'(carry_out), 32'h0);
        step();
        reset = 1'b1;
        step();
        send_frame(8'h3C, 1'b0, 1, 1'b0);
        chk("t6_result_after", 32'(result), 32'h3C);
        chk("t6_valid_after", 32'(out_valid), 32'h1);
        handshake();

        // Randomized frames with aborts, gaps, HOLD noise and back-to-back
        btb = 1'b0;
        for (int n = 0; n < 40; n++) begin
            w  = W'($urandom);
            cy = 1'($urandom);
            if (!btb && $urandom_range(0, 3) == 0) begin
                int k;
                k = int'($urandom_range(1, W - 1));
                start = 1'b1; s_valid = 1'b1; s_in = 1'($urandom);
                step();
                start = 1'b0;
                for (int j = 1; j < k; j++) begin
                    s_valid = 1'($urandom); s_in = 1'($urandom);
                    step();
                end
                s_valid = 1'b0;
            end
            send_frame(w, cy, int'($urandom_range(0, 2)), btb);
            chk("rnd_result", 32'(result), 32'(w));
            chk("rnd_carry", 32'(carry_out), 32'(cy));
            repeat ($urandom_range(0, 3)) begin
                start = 1'($urandom); s_valid = 1'($urandom);
                s_in = 1'($urandom); c_in = 1'($urandom);
                step();
            end
            start = 1'b0; s_valid = 1'b0; c_in = 1'b0;
            btb = 1'($urandom);
            if (!btb) handshake();
        end
        if (btb) handshake();
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
